vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 148 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: horizontal/vertical counters with registered sync,
// blanking, pixel coordinates and a multiplier-free linear pixel address.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int ROW_W    = 9,
  parameter int COL_W    = 10,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  output logic              hsync,
  output logic              vsync,
  output logic              active,
  output logic [COL_W-1:0]  col,
  output logic [ROW_W-1:0]  row,
  output logic [ADDR_W-1:0] addr,
  output logic              line_start,
  output logic              frame_start,
  output logic              vblank
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);

  localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT  = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] HS_BEG = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_END = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT  = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] VS_BEG = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_END = V_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  // Reject degenerate timings and address/coordinate ports too narrow for the raster.
  if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
      V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_bad_segment
    $error("vga_timing_gen: every timing segment must be non-zero");
  end
  if ((longint'(H_ACTIVE) * longint'(V_ACTIVE)) > (longint'(1) << ADDR_W)) begin : g_bad_addr
    $error("vga_timing_gen: ADDR_W too narrow for H_ACTIVE*V_ACTIVE");
  end
  if ((longint'(H_ACTIVE) > (longint'(1) << COL_W)) ||
      (longint'(V_ACTIVE) > (longint'(1) << ROW_W))) begin : g_bad_coord
    $error("vga_timing_gen: COL_W/ROW_W too narrow for the visible area");
  end

  logic [H_W-1:0]    r_h;
  logic [V_W-1:0]    r_v;
  logic [ADDR_W-1:0] r_addr;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic              r_hsync;
  logic              r_vsync;
  logic              r_active;
  logic              r_line_start;
  logic              r_frame_start;
  logic              r_vblank;

  logic              w_h_wrap;
  logic              w_v_wrap;
  logic [H_W-1:0]    w_h_nxt;
  logic [V_W-1:0]    w_v_nxt;
  logic              w_active_nxt;
  logic              w_origin_nxt;
  logic              w_hs_nxt;
  logic              w_vs_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;

  assign w_h_wrap = (r_h == H_LAST);
  assign w_v_wrap = (r_v == V_LAST);
  assign w_h_nxt  = w_h_wrap ? '0 : r_h + H_W'(1);
  assign w_v_nxt  = !w_h_wrap ? r_v : (w_v_wrap ? '0 : r_v + V_W'(1));

  // Outputs are decoded from the next counter values so every registered output
  // describes the same (h,v) as the counters after the edge.
  assign w_active_nxt = (w_h_nxt < H_ACT) && (w_v_nxt < V_ACT);
  assign w_origin_nxt = (w_h_nxt == '0) && (w_v_nxt == '0);
  assign w_hs_nxt     = (w_h_nxt >= HS_BEG) && (w_h_nxt < HS_END);
  assign w_vs_nxt     = (w_v_nxt >= VS_BEG) && (w_v_nxt < VS_END);

  // Raster order visits active pixels sequentially, so the address is a plain
  // counter that restarts at the frame origin and holds through blanking.
  always_comb begin
    // NOTE: default assigned first so no path leaves the signal unassigned (no latch).
    w_addr_nxt = r_addr;
    if (w_origin_nxt) begin
      w_addr_nxt = '0;
    end else if (w_active_nxt) begin
      w_addr_nxt = r_addr + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments; reset is synchronous
    // and checked before ce so it wins regardless of the pixel enable.
    if (rst) begin
      r_h           <= '0;
      r_v           <= '0;
      r_addr        <= '0;
      r_col         <= '0;
      r_row         <= '0;
      r_active      <= 1'b1;
      r_hsync       <= ~HS_ON;
      r_vsync       <= ~VS_ON;
      r_line_start  <= 1'b1;
      r_frame_start <= 1'b1;
      r_vblank      <= 1'b0;
    end else if (ce) begin
      r_h           <= w_h_nxt;
      r_v           <= w_v_nxt;
      r_addr        <= w_addr_nxt;
      r_col         <= w_active_nxt ? COL_W'(w_h_nxt) : '0;
      r_row         <= w_active_nxt ? ROW_W'(w_v_nxt) : '0;
      r_active      <= w_active_nxt;
      r_hsync       <= w_hs_nxt ? HS_ON : ~HS_ON;
      r_vsync       <= w_vs_nxt ? VS_ON : ~VS_ON;
      r_line_start  <= (w_h_nxt == '0);
      r_frame_start <= w_origin_nxt;
      r_vblank      <= (w_v_nxt >= V_ACT);
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign active      = r_active;
  assign col         = r_col;
  assign row         = r_row;
  assign addr        = r_addr;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign vblank      = r_vblank;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: three parameterisations share one stimulus
// stream; expected outputs are queued per cycle and a monitor per instance compares.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  typedef struct {
    int ha, hfp, hs, hbp, va, vfp, vs, vbp, hpol, vpol;
  } cfg_t;

  typedef struct {
    logic hs, vs, act, ls, fs, vb;
    int   col, row, addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ce  = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  cfg_t cfg [3];
  int   mh  [3];
  int   mv  [3];
  exp_t q0 [$];
  exp_t q1 [$];
  exp_t q2 [$];

  // Instance 0: defaults (640x480@60 timing).
  logic       d0_hsync, d0_vsync, d0_active, d0_ls, d0_fs, d0_vb;
  logic [9:0] d0_col;
  logic [8:0] d0_row;
  logic [18:0] d0_addr;
  vga_timing_gen u_dflt (
    .clk(clk), .rst(rst), .ce(ce),
    .hsync(d0_hsync), .vsync(d0_vsync), .active(d0_active),
    .col(d0_col), .row(d0_row), .addr(d0_addr),
    .line_start(d0_ls), .frame_start(d0_fs), .vblank(d0_vb)
  );

  // Instance 1: 800-wide line, positive sync polarities, short frame.
  logic       d1_hsync, d1_vsync, d1_active, d1_ls, d1_fs, d1_vb;
  logic [9:0] d1_col;
  logic [8:0] d1_row;
  logic [18:0] d1_addr;
  vga_timing_gen #(
    .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1), .VS_POL(1)
  ) u_pos (
    .clk(clk), .rst(rst), .ce(ce),
    .hsync(d1_hsync), .vsync(d1_vsync), .active(d1_active),
    .col(d1_col), .row(d1_row), .addr(d1_addr),
    .line_start(d1_ls), .frame_start(d1_fs), .vblank(d1_vb)
  );

  // Instance 2: tiny raster, power-of-two V_TOTAL and exactly-full address space.
  logic       d2_hsync, d2_vsync, d2_active, d2_ls, d2_fs, d2_vb;
  logic [2:0] d2_col;
  logic [1:0] d2_row;
  logic [4:0] d2_addr;
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .ROW_W(2), .COL_W(3), .ADDR_W(5)
  ) u_tiny (
    .clk(clk), .rst(rst), .ce(ce),
    .hsync(d2_hsync), .vsync(d2_vsync), .active(d2_active),
    .col(d2_col), .row(d2_row), .addr(d2_addr),
    .line_start(d2_ls), .frame_start(d2_fs), .vblank(d2_vb)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare(input string tag, input exp_t a, input exp_t e);
    check({tag, ".hsync"},       32'(a.hs),  32'(e.hs));
    check({tag, ".vsync"},       32'(a.vs),  32'(e.vs));
    check({tag, ".active"},      32'(a.act), 32'(e.act));
    check({tag, ".line_start"},  32'(a.ls),  32'(e.ls));
    check({tag, ".frame_start"}, 32'(a.fs),  32'(e.fs));
    check({tag, ".vblank"},      32'(a.vb),  32'(e.vb));
    check({tag, ".col"},         a.col,      e.col);
    check({tag, ".row"},         a.row,      e.row);
    check({tag, ".addr"},        a.addr,     e.addr);
  endtask

  // Reference: outputs as a pure function of raster position; the address is the
  // last visited active pixel, computed in closed form.
  function automatic exp_t model(input cfg_t c, input int h, input int v);
    exp_t e;
    logic hs_on, vs_on;
    e.act  = (h < c.ha) && (v < c.va);
    e.col  = e.act ? h : 0;
    e.row  = e.act ? v : 0;
    if (e.act)          e.addr = v * c.ha + h;
    else if (v >= c.va) e.addr = c.va * c.ha - 1;
    else                e.addr = v * c.ha + c.ha - 1;
    hs_on  = (h >= c.ha + c.hfp) && (h < c.ha + c.hfp + c.hs);
    vs_on  = (v >= c.va + c.vfp) && (v < c.va + c.vfp + c.vs);
    e.hs   = (c.hpol != 0) ? hs_on : !hs_on;
    e.vs   = (c.vpol != 0) ? vs_on : !vs_on;
    e.ls   = (h == 0);
    e.fs   = (h == 0) && (v == 0);
    e.vb   = (v >= c.va);
    return e;
  endfunction

  task automatic step(input logic c, input logic r);
    exp_t e;
    ce  = c;
    rst = r;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        mh[i] = 0;
        mv[i] = 0;
      end else if (c) begin
        mh[i]++;
        if (mh[i] == cfg[i].ha + cfg[i].hfp + cfg[i].hs + cfg[i].hbp) begin
          mh[i] = 0;
          mv[i]++;
          if (mv[i] == cfg[i].va + cfg[i].vfp + cfg[i].vs + cfg[i].vbp) mv[i] = 0;
        end
      end
      e = model(cfg[i], mh[i], mv[i]);
      case (i)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
    #1;
  endtask

  always @(negedge clk) begin
    exp_t a, e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      a.hs = d0_hsync; a.vs = d0_vsync; a.act = d0_active;
      a.ls = d0_ls; a.fs = d0_fs; a.vb = d0_vb;
      a.col = int'(d0_col); a.row = int'(d0_row); a.addr = int'(d0_addr);
      compare("dflt", a, e);
    end
  end

  always @(negedge clk) begin
    exp_t a, e;
    if (q1.size() > 0) begin
      e = q1.pop_front();
      a.hs = d1_hsync; a.vs = d1_vsync; a.act = d1_active;
      a.ls = d1_ls; a.fs = d1_fs; a.vb = d1_vb;
      a.col = int'(d1_col); a.row = int'(d1_row); a.addr = int'(d1_addr);
      compare("pos", a, e);
    end
  end

  always @(negedge clk) begin
    exp_t a, e;
    if (q2.size() > 0) begin
      e = q2.pop_front();
      a.hs = d2_hsync; a.vs = d2_vsync; a.act = d2_active;
      a.ls = d2_ls; a.fs = d2_fs; a.vb = d2_vb;
      a.col = int'(d2_col); a.row = int'(d2_row); a.addr = int'(d2_addr);
      compare("tiny", a, e);
    end
  end

  initial begin
    int guard;
    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0};
    cfg[1] = '{800, 40, 128, 88, 2, 1, 1, 1, 1, 1};
    cfg[2] = '{8, 2, 3, 2, 4, 1, 2, 1, 0, 0};
    for (int i = 0; i < 3; i++) begin
      mh[i] = 0;
      mv[i] = 0;
    end

    // Reset must win over ce in both states of the enable.
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);

    // Free-running pixel clock with a mid-frame reset and a reset while ce=0.
    for (int k = 0; k < 7000; k++) begin
      if (k == 5500)      step(1'b1, 1'b1);
      else if (k == 6500) step(1'b0, 1'b1);
      else                step(1'b1, 1'b0);
    end

    // One-in-four pixel enable: outputs must hold on idle cycles.
    for (int k = 0; k < 2000; k++) begin
      if (k == 1001) step(1'b0, 1'b1);
      else           step((k % 4) == 0, 1'b0);
    end

    guard = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && guard < 10) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check("scoreboard_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
